// File: rtl/exp_series_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exp_series_ctrl
// Function : Horner-rule Taylor-series sequencer for e^x (UQ0.16 in, UQ2.16 out)
// Revision : 1.0
// ============================================================================
module exp_series_ctrl #(
    parameter int MAX_TERMS = 16,
    parameter bit SAT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    input  logic [4:0]  terms,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        busy,
    output logic        done,
    output logic [17:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULX = 2'd1,
        S_MULR = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0]  MAX_TERMS_C = 5'(MAX_TERMS);
    localparam logic [17:0] ONE_C       = 18'h10000;

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [4:0]  k_q, k_d;
    logic [17:0] acc_q, acc_d;
    logic [17:0] p_q, p_d;
    logic [17:0] result_q, result_d;

    logic [4:0]  n_eff;
    logic [33:0] prod_x;
    logic [33:0] prod_r;
    logic [17:0] q_term;
    logic [18:0] sum;
    logic [17:0] acc_new;

    assign n_eff   = (terms > MAX_TERMS_C) ? MAX_TERMS_C : terms;
    assign prod_x  = 34'(acc_q) * 34'(x_q);
    assign prod_r  = 34'(p_q) * 34'(rom_data);
    // The last term multiplies by 1/1, which the ROM cannot represent.
    assign q_term  = (k_q == 5'd1) ? p_q : 18'(prod_r >> 16);
    assign sum     = 19'(ONE_C) + 19'(q_term);
    assign acc_new = (SAT_EN && sum[18]) ? 18'h3FFFF : sum[17:0];

    assign busy     = (state_q == S_MULX) || (state_q == S_MULR);
    assign done     = (state_q == S_DONE);
    assign rom_addr = busy ? 4'(k_q - 5'd1) : 4'd0;
    assign result   = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        k_d      = k_q;
        acc_d    = acc_q;
        p_d      = p_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d   = x;
                    acc_d = ONE_C;
                    k_d   = n_eff;
                    if (n_eff == 5'd0) begin
                        state_d  = S_DONE;
                        result_d = ONE_C;
                    end else begin
                        state_d = S_MULX;
                    end
                end
            end
            S_MULX: begin
                p_d     = 18'(prod_x >> 16);
                state_d = S_MULR;
            end
            S_MULR: begin
                acc_d = acc_new;
                k_d   = k_q - 5'd1;
                if (k_q == 5'd1) begin
                    state_d  = S_DONE;
                    result_d = acc_new;
                end else begin
                    state_d = S_MULX;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_series_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_series_ctrl
// Function : Scoreboard bench for exp_series_ctrl with a behavioural series model
// Revision : 1.0
// ============================================================================
module tb_exp_series_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [4:0]  terms;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy;
    logic        done;
    logic [17:0] result;

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] exp_q[$];
    logic [17:0] mon_exp;
    logic [15:0] rom_tbl[16];

    exp_series_ctrl #(.MAX_TERMS(16), .SAT_EN(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .terms    (terms),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reciprocal ROM: entry n holds 1/(n+1) in UQ0.16; entry 0 unused.
    initial begin
        rom_tbl[0] = 16'h0000;
        for (int n = 1; n < 16; n++) rom_tbl[n] = 16'(65536 / (n + 1));
    end
    always_comb rom_data = rom_tbl[rom_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // e^x = 1 + x(1 + x/2(1 + x/3(...))) evaluated with truncating fixed point.
    function automatic logic [17:0] model(input logic [15:0] xv, input int n);
        longint acc, p, q;
        int     ne;
        ne  = (n > 16) ? 16 : n;
        acc = 65536;
        for (int k = ne; k >= 1; k--) begin
            p = (acc * longint'(xv)) >> 16;
            if (k == 1) q = p;
            else        q = (p * longint'(65536 / k)) >> 16;
            acc = 65536 + (q % 262144);
            if (acc > 262143) acc = 262143;
        end
        return acc[17:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got result %0h, expected no done pulse", result);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 64'(result), 64'(mon_exp));
            end
        end
    end

    task automatic run_op(input logic [15:0] xv, input int n, input bit poke, output logic [17:0] got);
        int         ne;
        int         cyc;
        int         poke_cyc;
        int         nbad;
        logic [3:0] addrs[$];
        logic [3:0] exp_addrs[$];
        ne       = (n > 16) ? 16 : n;
        poke_cyc = (poke && ne >= 5) ? 2 * (ne - 5) : -1;
        for (int k = ne; k >= 1; k--) begin
            exp_addrs.push_back(4'(k - 1));
            exp_addrs.push_back(4'(k - 1));
        end
        @(negedge clk);
        x     = xv;
        terms = 5'(n);
        start = 1'b1;
        exp_q.push_back(model(xv, n));
        @(negedge clk);
        start = 1'b0;
        x     = 16'($urandom);
        terms = 5'($urandom);
        cyc   = 0;
        while (!done && cyc < 200) begin
            if (busy) addrs.push_back(rom_addr);
            start = (cyc == poke_cyc) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", 64'(cyc), 64'(2 * ne));
        check("busy_at_done", 64'(busy), 64'd0);
        got  = result;
        nbad = 0;
        for (int i = 0; i < exp_addrs.size(); i++)
            if (i >= addrs.size() || addrs[i] !== exp_addrs[i]) nbad++;
        check("rom_addr_seq_len", 64'(addrs.size()), 64'(exp_addrs.size()));
        check("rom_addr_seq_bad", 64'(nbad), 64'd0);
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] g, g1, g2;
        int          seen;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        terms = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("reset_idle", 64'({busy, done, result, rom_addr}), 64'd0);
        end

        run_op(16'h8000, 1, 1'b0, g);
        check("half_n1", 64'(g), 64'h18000);
        run_op(16'h8000, 2, 1'b0, g);
        check("half_n2", 64'(g), 64'h1A000);
        run_op(16'h0000, 8, 1'b0, g);
        check("zero_x", 64'(g), 64'h10000);
        run_op(16'hFFFF, 16, 1'b0, g1);
        run_op(16'hFFFF, 31, 1'b0, g2);
        check("clamp_equal", 64'(g2), 64'(g1));
        check("full_in_range", 64'((g1 >= 18'h2B7B0) && (g1 <= 18'h2B7E1)), 64'd1);
        run_op(16'h1234, 0, 1'b0, g);
        check("zero_terms", 64'(g), 64'h10000);
        run_op(16'hC3A5, 12, 1'b1, g);

        // Reset while the first term is in its reciprocal-multiply step.
        @(negedge clk);
        x     = 16'h7777;
        terms = 5'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_state", 64'({busy, done, result, rom_addr}), 64'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_reset", 64'(seen), 64'd0);
        run_op(16'h7777, 8, 1'b0, g);

        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)), g);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
